factorial_ctrl_param: RTL and testbench



---
 rtl/fact_pkg.sv | 35 +++
 rtl/fact_regbank.sv | 84 ++++++++
 rtl/factorial_ctrl_param.sv | 140 ++++++++++++++
 tb/tb_factorial_ctrl_param.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial controller: FSM states,
// register word offsets and opdone bit positions.
package fact_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MSTART,
    MWAIT,
    DONE
  } state_t;

  localparam int NUM_REGS     = 7;
  localparam int OFF_OPSTART  = 0;
  localparam int OFF_OPCLEAR  = 1;
  localparam int OFF_OPDONE   = 2;
  localparam int OFF_INTREN   = 3;
  localparam int OFF_OPERAND  = 4;
  localparam int OFF_RESULT_H = 5;
  localparam int OFF_RESULT_L = 6;

  localparam int OPDONE_DONE = 0;
  localparam int OPDONE_BUSY = 1;
  localparam int OPDONE_OVF  = 2;

  function automatic logic [2:0] opdone_bits(input logic done, input logic busy,
                                             input logic ovf);
    logic [2:0] v;
    v = '0;
    v[OPDONE_DONE] = done;
    v[OPDONE_BUSY] = busy;
    v[OPDONE_OVF]  = ovf;
    return v;
  endfunction

endpackage

// File: rtl/fact_regbank.sv
// Software-visible register storage, write decode and combinational read mux.
// opdone and the result come from the controller; everything else lives here.
module fact_regbank
  import fact_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_sel,
  input  logic                  s_wr,
  input  logic [ADDR_W-1:0]     s_addr,
  input  logic [DATA_W-1:0]     s_din,
  input  logic [2:0]            opdone,
  input  logic [2*DATA_W-1:0]   acc,
  output logic [DATA_W-1:0]     s_dout,
  output logic [DATA_W-1:0]     operand,
  output logic                  intr_en0,
  output logic                  start_cmd,
  output logic                  clear_cmd
);

  logic [DATA_W-1:0] opstart_q, opstart_d;
  logic [DATA_W-1:0] opclear_q, opclear_d;
  logic [DATA_W-1:0] intr_en_q, intr_en_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [NUM_REGS-1:0] addr_hit;
  logic [NUM_REGS-1:0] wr_hit;
  logic [DATA_W-1:0] rd_val [NUM_REGS];

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
    assign addr_hit[gi] = s_sel && (s_addr == ADDR_W'(gi));
    assign wr_hit[gi]   = addr_hit[gi] && s_wr;
  end

  assign rd_val[OFF_OPSTART]  = opstart_q;
  assign rd_val[OFF_OPCLEAR]  = opclear_q;
  assign rd_val[OFF_OPDONE]   = DATA_W'(opdone);
  assign rd_val[OFF_INTREN]   = intr_en_q;
  assign rd_val[OFF_OPERAND]  = operand_q;
  assign rd_val[OFF_RESULT_H] = acc[2*DATA_W-1:DATA_W];
  assign rd_val[OFF_RESULT_L] = acc[DATA_W-1:0];

  assign start_cmd = wr_hit[OFF_OPSTART] & s_din[0];
  assign clear_cmd = wr_hit[OFF_OPCLEAR] & s_din[0];
  assign operand   = operand_q;
  assign intr_en0  = intr_en_q[0];

  always_comb begin
    opstart_d = opstart_q;
    opclear_d = opclear_q;
    intr_en_d = intr_en_q;
    operand_d = operand_q;
    if (wr_hit[OFF_OPSTART]) opstart_d = s_din;
    if (wr_hit[OFF_OPCLEAR]) opclear_d = s_din;
    if (clear_cmd)           opstart_d = '0;
    if (wr_hit[OFF_INTREN])  intr_en_d = s_din;
    // Operand is frozen while a computation is using it.
    if (wr_hit[OFF_OPERAND] && !opdone[OPDONE_BUSY]) operand_d = s_din;
  end

  always_comb begin
    s_dout = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_hit[i]) s_dout = s_dout | rd_val[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opstart_q <= '0;
      opclear_q <= '0;
      intr_en_q <= '0;
      operand_q <= '0;
    end else begin
      opstart_q <= opstart_d;
      opclear_q <= opclear_d;
      intr_en_q <= intr_en_d;
      operand_q <= operand_d;
    end
  end

endmodule

// File: rtl/factorial_ctrl_param.sv
// Factorial controller: sequences an external iterative multiplier to build
// n! in a double-width accumulator, with overflow stop, abort and interrupt.
module factorial_ctrl_param
  import fact_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_sel,
  input  logic                  s_wr,
  input  logic [ADDR_W-1:0]     s_addr,
  input  logic [DATA_W-1:0]     s_din,
  output logic [DATA_W-1:0]     s_dout,
  output logic [DATA_W-1:0]     mul_a,
  output logic [DATA_W-1:0]     mul_b,
  output logic                  mul_start,
  output logic                  mul_clear,
  input  logic [2*DATA_W-1:0]   mul_result,
  input  logic                  mul_done,
  output logic                  intr
);

  localparam int ACC_W = 2 * DATA_W;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic [DATA_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic              mul_start_q, mul_start_d;
  logic              mul_clear_q, mul_clear_d;
  logic [2:0]        opdone_q, opdone_d;
  logic [DATA_W-1:0] operand;
  logic              intr_en0, start_cmd, clear_cmd;

  fact_regbank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_regbank (
    .clk       (clk),
    .reset     (reset),
    .s_sel     (s_sel),
    .s_wr      (s_wr),
    .s_addr    (s_addr),
    .s_din     (s_din),
    .opdone    (opdone_q),
    .acc       (acc_q),
    .s_dout    (s_dout),
    .operand   (operand),
    .intr_en0  (intr_en0),
    .start_cmd (start_cmd),
    .clear_cmd (clear_cmd)
  );

  assign cnt_dec = cnt_q - DATA_W'(1);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    opdone_d    = opdone_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_start_d = 1'b0;
    mul_clear_d = 1'b0;
    // Clear takes priority over everything, including a coincident mul_done.
    if (clear_cmd) begin
      state_d     = IDLE;
      acc_d       = ACC_W'(1);
      opdone_d    = '0;
      mul_clear_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (start_cmd) begin
          acc_d = ACC_W'(1);
          if (operand <= DATA_W'(1)) begin
            opdone_d = opdone_bits(1'b1, 1'b0, 1'b0);
            state_d  = DONE;
          end else begin
            cnt_d    = operand;
            opdone_d = opdone_bits(1'b0, 1'b1, 1'b0);
            state_d  = MSTART;
          end
        end
        MSTART: begin
          // A non-zero upper half means the next product cannot fit.
          if (acc_q[ACC_W-1:DATA_W] != '0) begin
            opdone_d = opdone_bits(1'b1, 1'b0, 1'b1);
            state_d  = DONE;
          end else begin
            mul_a_d     = acc_q[DATA_W-1:0];
            mul_b_d     = cnt_q;
            mul_start_d = 1'b1;
            state_d     = MWAIT;
          end
        end
        MWAIT: if (mul_done) begin
          acc_d       = mul_result;
          cnt_d       = cnt_dec;
          mul_clear_d = 1'b1;
          if (cnt_dec == DATA_W'(1)) begin
            opdone_d = opdone_bits(1'b1, 1'b0, 1'b0);
            state_d  = DONE;
          end else begin
            state_d = MSTART;
          end
        end
        DONE:    ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= ACC_W'(1);
      cnt_q       <= '0;
      opdone_q    <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
      mul_clear_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      opdone_q    <= opdone_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_start_q <= mul_start_d;
      mul_clear_q <= mul_clear_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_start = mul_start_q;
  assign mul_clear = mul_clear_q;
  assign intr      = intr_en0 & opdone_q[OPDONE_DONE];

endmodule

// File: tb/tb_factorial_ctrl_param.sv
// Directed bench for factorial_ctrl_param: an 8-bit and a 64-bit instance,
// each driven by a behavioural fixed-latency multiplier, checked via a scoreboard.
module tb_factorial_ctrl_param;

  localparam int A_OPSTART  = 0;
  localparam int A_OPCLEAR  = 1;
  localparam int A_OPDONE   = 2;
  localparam int A_INTREN   = 3;
  localparam int A_OPERAND  = 4;
  localparam int A_RESULT_H = 5;
  localparam int A_RESULT_L = 6;
  localparam int LM         = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_wr = 1'b0;
  logic        sel8 = 1'b0;
  logic        sel64 = 1'b0;
  logic [4:0]  s_addr = '0;
  logic [63:0] s_din = '0;

  logic [7:0]   dout8, mul8_a, mul8_b;
  logic         mul8_start, mul8_clear, intr8;
  logic [15:0]  mul8_result = '0;
  logic         mul8_done = 1'b0;
  logic [63:0]  dout64, mul64_a, mul64_b;
  logic         mul64_start, mul64_clear, intr64;
  logic [127:0] mul64_result = '0;
  logic         mul64_done = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int starts8 = 0, starts64 = 0, clears8 = 0;

  always #5 clk = ~clk;

  factorial_ctrl_param #(.DATA_W(8), .ADDR_W(5)) u_dut8 (
    .clk(clk), .reset(reset), .s_sel(sel8), .s_wr(s_wr), .s_addr(s_addr),
    .s_din(s_din[7:0]), .s_dout(dout8), .mul_a(mul8_a), .mul_b(mul8_b),
    .mul_start(mul8_start), .mul_clear(mul8_clear), .mul_result(mul8_result),
    .mul_done(mul8_done), .intr(intr8)
  );

  factorial_ctrl_param #(.DATA_W(64), .ADDR_W(5)) u_dut64 (
    .clk(clk), .reset(reset), .s_sel(sel64), .s_wr(s_wr), .s_addr(s_addr),
    .s_din(s_din), .s_dout(dout64), .mul_a(mul64_a), .mul_b(mul64_b),
    .mul_start(mul64_start), .mul_clear(mul64_clear), .mul_result(mul64_result),
    .mul_done(mul64_done), .intr(intr64)
  );

  // Fixed-latency multipliers; they ignore clear and reset so a late done can arrive.
  logic [15:0]  p8;
  logic [127:0] p64;
  int c8 = 0, c64 = 0;
  always @(posedge clk) begin
    mul8_done  <= 1'b0;
    mul64_done <= 1'b0;
    if (mul8_start === 1'b1) begin
      p8 <= 16'(mul8_a) * 16'(mul8_b);
      c8 <= LM;
    end else if (c8 != 0) begin
      c8 <= c8 - 1;
      if (c8 == 1) begin mul8_done <= 1'b1; mul8_result <= p8; end
    end
    if (mul64_start === 1'b1) begin
      p64 <= 128'(mul64_a) * 128'(mul64_b);
      c64 <= LM;
    end else if (c64 != 0) begin
      c64 <= c64 - 1;
      if (c64 == 1) begin mul64_done <= 1'b1; mul64_result <= p64; end
    end
  end

  always @(posedge clk) begin
    if (mul8_start === 1'b1)  starts8++;
    if (mul64_start === 1'b1) starts64++;
    if (mul8_clear === 1'b1)  clears8++;
  end

  typedef struct {
    string        tag;
    logic [127:0] res;
    logic [2:0]   od;
    int           starts;
    int           wait_exact;
    logic         intr;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input bit big, input int addr, input logic [63:0] data);
    @(negedge clk);
    sel8 = !big; sel64 = big; s_wr = 1'b1; s_addr = 5'(addr); s_din = data;
    @(negedge clk);
    sel8 = 1'b0; sel64 = 1'b0; s_wr = 1'b0;
  endtask

  task automatic rd(input bit big, input int addr, output logic [63:0] data);
    sel8 = !big; sel64 = big; s_wr = 1'b0; s_addr = 5'(addr);
    #1;
    data = big ? dout64 : {56'b0, dout8};
    sel8 = 1'b0; sel64 = 1'b0;
  endtask

  task automatic rd_res(input bit big, output logic [127:0] r);
    logic [63:0] h, l;
    rd(big, A_RESULT_H, h);
    rd(big, A_RESULT_L, l);
    r = big ? {h, l} : {112'b0, h[7:0], l[7:0]};
  endtask

  task automatic run(input bit big, input logic [63:0] n, input logic [127:0] res,
                     input logic [2:0] od, input int nst, input int wexact,
                     input logic ex_intr, input bit do_clear, input string tag);
    exp_t e;
    logic [63:0] v;
    logic [127:0] r;
    int base, w;
    base = big ? starts64 : starts8;
    wr(big, A_OPERAND, n);
    sb.push_back('{tag: tag, res: res, od: od, starts: nst, wait_exact: wexact, intr: ex_intr});
    wr(big, A_OPSTART, 64'd1);
    w = 0;
    rd(big, A_OPDONE, v);
    while (v[0] !== 1'b1 && w < 5000) begin
      @(negedge clk);
      w++;
      rd(big, A_OPDONE, v);
    end
    e = sb.pop_front();
    check({e.tag, " opdone"}, 128'(v), 128'(e.od));
    rd_res(big, r);
    check({e.tag, " result"}, r, e.res);
    check({e.tag, " mul_starts"}, 128'((big ? starts64 : starts8) - base), 128'(e.starts));
    if (e.wait_exact >= 0) check({e.tag, " latency"}, 128'(w), 128'(e.wait_exact));
    check({e.tag, " intr"}, 128'(big ? intr64 : intr8), 128'(e.intr));
    $display("run %s: n=%0d result=0x%0h opdone=%03b cycles=%0d", e.tag, n, r, v[2:0], w);
    if (do_clear) wr(big, A_OPCLEAR, 64'd1);
  endtask

  initial begin
    logic [63:0] v;
    int b, cb, w;

    repeat (3) @(negedge clk);
    check("rst mul_clear", 128'(mul8_clear), 128'(1));
    check("rst mul_start", 128'(mul8_start), 128'(0));
    check("rst mul_a", 128'(mul8_a), 128'(0));
    check("rst intr", 128'(intr8), 128'(0));
    rd(1'b0, A_RESULT_L, v); check("rst result_l", 128'(v), 128'(1));
    rd(1'b0, A_OPDONE, v);   check("rst opdone", 128'(v), 128'(0));
    check("rst mul_clear64", 128'(mul64_clear), 128'(1));
    reset = 1'b0;
    @(negedge clk);
    check("post-rst mul_clear", 128'(mul8_clear), 128'(0));

    run(1'b0, 64'd5, 128'h78,  3'b001, 4, -1, 1'b0, 1'b1, "w8 n=5");
    run(1'b0, 64'd0, 128'h1,   3'b001, 0,  0, 1'b0, 1'b1, "w8 n=0");
    run(1'b0, 64'd1, 128'h1,   3'b001, 0,  0, 1'b0, 1'b1, "w8 n=1");
    run(1'b0, 64'd6, 128'h168, 3'b101, 4, -1, 1'b0, 1'b1, "w8 n=6 ovf");

    wr(1'b1, A_INTREN, 64'd1);
    rd(1'b1, A_INTREN, v); check("intrEN readback", 128'(v), 128'(1));
    run(1'b1, 64'd20, 128'd2432902008176640000, 3'b001, 19, -1, 1'b1, 1'b0, "w64 n=20");

    // Abort during the second multiply.
    b = starts8;
    wr(1'b0, A_OPERAND, 64'd5);
    wr(1'b0, A_OPSTART, 64'd1);
    w = 0;
    while (starts8 - b < 2 && w < 200) begin @(negedge clk); w++; end
    check("abort second start", 128'(starts8 - b), 128'(2));
    wr(1'b0, A_OPERAND, 64'd9);
    rd(1'b0, A_OPERAND, v);  check("busy operand write", 128'(v), 128'(5));
    rd(1'b0, A_OPDONE, v);   check("busy opdone", 128'(v), 128'(3'b010));
    rd(1'b0, A_RESULT_L, v); check("partial acc", 128'(v), 128'(5));
    wr(1'b0, A_OPCLEAR, 64'd1);
    cb = clears8;
    check("abort mul_clear", 128'(mul8_clear), 128'(1));
    rd(1'b0, A_OPDONE, v);   check("abort opdone", 128'(v), 128'(0));
    rd(1'b0, A_RESULT_L, v); check("abort result_l", 128'(v), 128'(1));
    rd(1'b0, A_OPSTART, v);  check("abort opstart", 128'(v), 128'(0));
    repeat (12) @(negedge clk);
    check("abort single clear", 128'(clears8 - cb), 128'(1));
    rd(1'b0, A_RESULT_L, v); check("late done result_l", 128'(v), 128'(1));
    rd(1'b0, A_OPDONE, v);   check("late done opdone", 128'(v), 128'(0));
    rd(1'b0, A_OPERAND, v);  check("abort operand kept", 128'(v), 128'(5));
    check("late done no restart", 128'(starts8 - b), 128'(2));
    $display("abort: operand=%0d clears=%0d", v, clears8 - cb);

    // Reset while waiting on the multiplier.
    b = starts8;
    wr(1'b0, A_OPERAND, 64'd5);
    wr(1'b0, A_OPSTART, 64'd1);
    w = 0;
    while (starts8 - b < 1 && w < 200) begin @(negedge clk); w++; end
    check("pre-reset mul_b", 128'(mul8_b), 128'(5));
    reset = 1'b1;
    @(negedge clk);
    check("mwait rst mul_clear", 128'(mul8_clear), 128'(1));
    check("mwait rst mul_start", 128'(mul8_start), 128'(0));
    check("mwait rst mul_a", 128'(mul8_a), 128'(0));
    check("mwait rst mul_b", 128'(mul8_b), 128'(0));
    check("mwait rst intr64", 128'(intr64), 128'(0));
    rd(1'b0, A_OPDONE, v);   check("mwait rst opdone", 128'(v), 128'(0));
    rd(1'b0, A_RESULT_L, v); check("mwait rst result_l", 128'(v), 128'(1));
    rd(1'b0, A_OPERAND, v);  check("mwait rst operand", 128'(v), 128'(0));
    rd(1'b1, A_RESULT_L, v); check("mwait rst result_l64", 128'(v), 128'(1));
    reset = 1'b0;
    repeat (10) @(negedge clk);
    rd(1'b0, A_OPDONE, v);   check("post-rst opdone", 128'(v), 128'(0));
    rd(1'b0, A_RESULT_L, v); check("post-rst result_l", 128'(v), 128'(1));
    check("post-rst no restart", 128'(starts8 - b), 128'(1));
    check("post-rst mul_clear", 128'(mul8_clear), 128'(0));
    $display("reset-in-mwait: result_l=%0d", v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
